pattern_detector_param: RTL and testbench

//  Runtime-programmable serial bit-pattern detector; generalises the fixed 4-bit Mealy detector.

---
 rtl/pattern_det_pkg.sv | 15 +
 rtl/pattern_det_cmp.sv | 24 ++
 rtl/pattern_detector_param.sv | 111 +++++++++++
 tb/tb_pattern_detector_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package pattern_det_pkg;

  typedef enum logic [1:0] {
    UNCFG  = 2'd0,
    FILL   = 2'd1,
    DETECT = 2'd2
  } det_state_t;

  // A pattern length is usable only if it lies in 1..max.
  function automatic logic len_legal(input int len, input int max);
    return (len >= 1) && (len <= max);
  endfunction

endpackage

// File: rtl/pattern_det_cmp.sv
// Masked history-vs-pattern comparator: only the low `len` bits take part.
module pattern_det_cmp #(
  parameter int W     = 8,
  parameter int LEN_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     hist,
  input  logic [W-1:0]     pat,
  input  logic [LEN_W-1:0] len,
  output logic             eq
);

  logic [W-1:0] mask;

  // Build a thermometer mask covering bit positions below len.
  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign eq = (((hist ^ pat) & mask) == '0);

endmodule

// File: rtl/pattern_detector_param.sv
// Runtime-programmable serial bit-pattern detector with Mealy or Moore match timing.
//
// state  | meaning
// UNCFG  | no legal configuration yet; input stream ignored
// FILL   | history holds fewer than len valid bits
// DETECT | history full; every valid bit is compared
module pattern_detector_param
  import pattern_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 16,
  parameter bit MEALY   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  det_state_t         state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic               match_q;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic               cmp_eq;
  logic               cfg_ok;
  logic               hit;

  pattern_det_cmp #(
    .W     (MAX_LEN),
    .LEN_W (LEN_W)
  ) u_cmp (
    .hist (hist_nxt),
    .pat  (pat_q),
    .len  (len_q),
    .eq   (cmp_eq)
  );

  // Next history/fill, hit decision and match output. A cfg_load in the
  // same cycle as a valid bit drops the bit, so it can never produce a hit.
  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], in_bit};
    fill_nxt = (fill >= len_q) ? len_q : fill + LEN_W'(1);
    cfg_ok   = len_legal(int'(cfg_len), MAX_LEN);
    hit      = !reset && !cfg_load && in_valid && (state != UNCFG) &&
               (fill_nxt >= len_q) && cmp_eq;
    match    = MEALY ? hit : match_q;
  end

  // Configuration, history shift, FSM, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= UNCFG;
      pat_q       <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      match_q     <= 1'b0;
      match_count <= '0;
      armed       <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      match_q <= hit;
      if (cfg_load) begin
        if (cfg_ok) begin
          pat_q       <= cfg_pattern;
          len_q       <= cfg_len;
          overlap_q   <= cfg_overlap;
          hist        <= '0;
          fill        <= '0;
          match_count <= '0;
          armed       <= 1'b1;
          state       <= FILL;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (in_valid && (state != UNCFG)) begin
        if (hit && (match_count != '1)) begin
          match_count <= match_count + CNT_W'(1);
        end
        if (hit && !overlap_q) begin
          // Non-overlapping: the matching bit is consumed, start afresh.
          hist  <= '0;
          fill  <= '0;
          state <= FILL;
        end else begin
          hist  <= hist_nxt;
          fill  <= fill_nxt;
          state <= (fill_nxt >= len_q) ? DETECT : FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_detector_param.sv
// Table-driven bench for pattern_detector_param: a Mealy instance (16-bit count)
// and a Moore instance (3-bit count) share one stimulus stream.
module tb_pattern_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;

  logic        err1, armed1, match1;
  logic [15:0] cnt1;
  logic        err2, armed2, match2;
  logic [2:0]  cnt2;

  pattern_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(16), .MEALY(1'b1)) u_mealy (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(err1),
    .in_valid(in_valid), .in_bit(in_bit), .armed(armed1), .match(match1),
    .match_count(cnt1)
  );

  pattern_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(3), .MEALY(1'b0)) u_moore (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(err2),
    .in_valid(in_valid), .in_bit(in_bit), .armed(armed2), .match(match2),
    .match_count(cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       v;
    logic       b;
    logic       m;
    int         cnt;
    logic       arm;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  logic mq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic rst, input logic ld, input logic [7:0] pat,
                              input logic [3:0] len, input logic ovl, input logic v,
                              input logic b, input logic m, input int cnt,
                              input logic arm, input logic err);
    vec_t t;
    t.rst = rst; t.ld = ld; t.pat = pat; t.len = len; t.ovl = ovl;
    t.v = v; t.b = b; t.m = m; t.cnt = cnt; t.arm = arm; t.err = err;
    vecs.push_back(t);
  endfunction

  function automatic void add_load(input logic [7:0] pat, input logic [3:0] len,
                                   input logic ovl);
    add(1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
  endfunction

  function automatic void add_bit(input logic b, input logic m, input int cnt);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, m, cnt, 1'b1, 1'b0);
  endfunction

  function automatic void add_idle(input int cnt);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, cnt, 1'b1, 1'b0);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset       = t.rst;
    cfg_load    = t.ld;
    cfg_pattern = t.pat;
    cfg_len     = t.len;
    cfg_overlap = t.ovl;
    in_valid    = t.v;
    in_bit      = t.b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t t;
    logic exp_m;
    int   mc;
    int   found;
    logic [7:0] lp;

    // Table: reset, then the main scenarios.
    add(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // Overlapping 1101 over 1101101
    add_load(8'h0D, 4'd4, 1'b1);
    add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 1, 1);
    add_bit(1, 0, 1); add_bit(0, 0, 1); add_bit(1, 1, 2);
    // Illegal lengths leave config, count and armed untouched
    add(1'b0, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'hFF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    add_idle(2);
    add_bit(1, 0, 2); add_bit(0, 0, 2); add_bit(1, 1, 3);
    // Non-overlapping over the same stream
    add_load(8'h0D, 4'd4, 1'b0);
    add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 1, 1);
    add_bit(1, 0, 1); add_bit(0, 0, 1); add_bit(1, 0, 1);
    // Gaps of three invalid cycles between bits
    add_load(8'h0D, 4'd4, 1'b1);
    add_bit(1, 0, 0); add_idle(0); add_idle(0); add_idle(0);
    add_bit(1, 0, 0); add_idle(0); add_idle(0); add_idle(0);
    add_bit(0, 0, 0); add_idle(0); add_idle(0); add_idle(0);
    add_bit(1, 1, 1);
    // Reload mid-pattern clears history
    add_load(8'h0D, 4'd4, 1'b1);
    add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0);
    add_load(8'h0D, 4'd4, 1'b1);
    add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 1, 1);
    // len=1 loaded with a valid bit in the same cycle (dropped); Moore pulse still due
    add(1'b0, 1'b1, 8'hFF, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) add_bit(1, 1, i);
    add_bit(0, 0, 5); add_idle(5);
    for (int i = 6; i <= 9; i++) add_bit(1, 1, i);
    // len=3 pattern 101 with don't-care upper bits, overlapping
    add_load(8'hFD, 4'd3, 1'b1);
    add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 1, 1); add_bit(0, 0, 1); add_bit(1, 1, 2);
    // Reset beats cfg_load; stream ignored while unconfigured
    add(1'b1, 1'b1, 8'h0D, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h0D, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Initial reset and reset-state check
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_armed", -1, 32'(armed1), 0);
    chk("rst_count", -1, 32'(cnt1), 0);
    chk("rst_err",   -1, 32'(err1), 0);
    chk("rst_match_moore", -1, 32'(match2), 0);
    mq.push_back(1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      t = vecs[k];
      drive(t);
      @(negedge clk);
      chk("mealy_match", k, 32'(match1), 32'(t.m));
      exp_m = mq.pop_front();
      chk("moore_match", k, 32'(match2), 32'(exp_m));
      mq.push_back(t.rst ? 1'b0 : t.m);
      @(posedge clk); #1;
      mc = (t.cnt > 7) ? 7 : t.cnt;
      chk("mealy_count", k, 32'(cnt1), 32'(t.cnt));
      chk("moore_count", k, 32'(cnt2), 32'(mc));
      chk("armed", k, 32'(armed1), 32'(t.arm));
      chk("armed_moore", k, 32'(armed2), 32'(t.arm));
      chk("cfg_err", k, 32'(err1), 32'(t.err));
      chk("cfg_err_moore", k, 32'(err2), 32'(t.err));
    end

    // Full-width 8-bit pattern: wait (bounded) for the Mealy hit
    lp = 8'hB3;
    reset = 1'b0; cfg_load = 1'b1; cfg_pattern = lp; cfg_len = 4'd8;
    cfg_overlap = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    found = -1;
    for (int i = 0; i < 20 && found < 0; i++) begin
      in_valid = (i < 8);
      in_bit   = (i < 8) ? lp[7-i] : 1'b0;
      @(negedge clk);
      if (match1 === 1'b1) found = i;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("len8_hit_index", 100, 32'(found), 7);
    chk("len8_count", 100, 32'(cnt1), 1);
    chk("len8_moore_late", 100, 32'(match2), 1);
    @(negedge clk);
    chk("len8_mealy_idle", 101, 32'(match1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
